// File: rtl/control_sequencer.sv
// Moore control sequencer for the Mini SRC datapath: fetch/execute T-states, register-select and bus strobes.
// Optional memory-ready wait states in T1/T6/T7 are enabled by defining MEM_HANDSHAKE_EN.
module control_sequencer (
   input  logic        clk,
   input  logic        clear,
   input  logic [31:0] IR,
   input  logic        mem_ready,
   output logic        PCout,
   output logic        PCin,
   output logic        IncPC,
   output logic        MARin,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Yin,
   output logic        Zin,
   output logic        Zlowout,
   output logic        Cout,
   output logic        Read,
   output logic        Write,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic [4:0]  alu_op,
   output logic        run
);

   localparam int unsigned OP_W = 5;

   localparam logic [OP_W-1:0] OP_LD    = 5'b00000;
   localparam logic [OP_W-1:0] OP_LDI   = 5'b00001;
   localparam logic [OP_W-1:0] OP_ST    = 5'b00010;
   localparam logic [OP_W-1:0] OP_ADD   = 5'b00011;
   localparam logic [OP_W-1:0] OP_SHL   = 5'b01011;
   localparam logic [OP_W-1:0] OP_ADDI  = 5'b01100;
   localparam logic [OP_W-1:0] OP_ORI   = 5'b01110;
   localparam logic [OP_W-1:0] OP_HALT  = 5'b11011;

   typedef enum logic [3:0] {
      T0   = 4'd0,
      T1   = 4'd1,
      T2   = 4'd2,
      T3   = 4'd3,
      T4   = 4'd4,
      T5   = 4'd5,
      T6   = 4'd6,
      T7   = 4'd7,
      HALT = 4'd8
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [OP_W-1:0] opcode;
   logic            is_rtype;
   logic            is_itype;
   logic            is_ldi;
   logic            is_ld;
   logic            is_st;
   logic            is_halt;
   logic            is_based;
   logic            mem_go;
   logic            unused_ir;

   // Instruction class decode; only the opcode field matters to sequencing.
   assign opcode    = IR[31:27];
   assign unused_ir = ^IR[26:0];
   assign is_rtype  = (opcode >= OP_ADD) && (opcode <= OP_SHL);
   assign is_itype  = (opcode >= OP_ADDI) && (opcode <= OP_ORI);
   assign is_ldi    = (opcode == OP_LDI);
   assign is_ld     = (opcode == OP_LD);
   assign is_st     = (opcode == OP_ST);
   assign is_halt   = (opcode == OP_HALT);
   assign is_based  = is_ldi | is_ld | is_st;

`ifdef MEM_HANDSHAKE_EN
   assign mem_go = mem_ready;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready;
   assign mem_go           = 1'b1;
`endif

   // Next-state selection; memory states hold until mem_go.
   always_comb begin
      state_nx = state;
      case (state)
         T0: state_nx = T1;
         T1: state_nx = mem_go ? T2 : T1;
         T2: state_nx = T3;
         T3: begin
            if (is_halt)
               state_nx = HALT;
            else if (is_rtype || is_itype || is_based)
               state_nx = T4;
            else
               state_nx = T0;
         end
         T4: state_nx = (is_rtype || is_itype || is_based) ? T5 : T0;
         T5: state_nx = (is_ld || is_st) ? T6 : T0;
         T6: begin
            if (is_ld)
               state_nx = mem_go ? T7 : T6;
            else if (is_st)
               state_nx = T7;
            else
               state_nx = T0;
         end
         T7: begin
            if (is_st)
               state_nx = mem_go ? T0 : T7;
            else
               state_nx = T0;
         end
         HALT:    state_nx = HALT;
         default: state_nx = T0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clear)
         state <= T0;
      else
         state <= state_nx;
   end

   // Moore strobe decode from the T-state and the instruction class.
   always_comb begin
      PCout   = 1'b0;
      PCin    = 1'b0;
      IncPC   = 1'b0;
      MARin   = 1'b0;
      MDRin   = 1'b0;
      MDRout  = 1'b0;
      IRin    = 1'b0;
      Yin     = 1'b0;
      Zin     = 1'b0;
      Zlowout = 1'b0;
      Cout    = 1'b0;
      Read    = 1'b0;
      Write   = 1'b0;
      Gra     = 1'b0;
      Grb     = 1'b0;
      Grc     = 1'b0;
      Rin     = 1'b0;
      Rout    = 1'b0;
      BAout   = 1'b0;
      alu_op  = '0;
      run     = 1'b1;
      case (state)
         T0: begin
            PCout = 1'b1;
            MARin = 1'b1;
            IncPC = 1'b1;
            Zin   = 1'b1;
         end
         T1: begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
         end
         T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         T3: begin
            if (is_rtype || is_itype) begin
               Grb  = 1'b1;
               Rout = 1'b1;
               Yin  = 1'b1;
            end else if (is_based) begin
               Grb   = 1'b1;
               BAout = 1'b1;
               Yin   = 1'b1;
            end
         end
         T4: begin
            if (is_rtype) begin
               Grc    = 1'b1;
               Rout   = 1'b1;
               Zin    = 1'b1;
               alu_op = opcode;
            end else if (is_itype) begin
               Cout   = 1'b1;
               Zin    = 1'b1;
               alu_op = opcode;
            end else if (is_based) begin
               Cout   = 1'b1;
               Zin    = 1'b1;
               alu_op = OP_ADD;
            end
         end
         T5: begin
            if (is_rtype || is_itype || is_ldi) begin
               Zlowout = 1'b1;
               Gra     = 1'b1;
               Rin     = 1'b1;
            end else if (is_ld || is_st) begin
               Zlowout = 1'b1;
               MARin   = 1'b1;
            end
         end
         T6: begin
            if (is_ld) begin
               Read  = 1'b1;
               MDRin = 1'b1;
            end else if (is_st) begin
               Gra   = 1'b1;
               Rout  = 1'b1;
               MDRin = 1'b1;
            end
         end
         T7: begin
            if (is_ld) begin
               MDRout = 1'b1;
               Gra    = 1'b1;
               Rin    = 1'b1;
            end else if (is_st) begin
               Write = 1'b1;
            end
         end
         HALT:    run = 1'b0;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-instruction strobe sequences built from the
// instruction-class tables and compared cycle by cycle against the DUT.
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        clear = 1'b1;
   logic        mem_ready = 1'b0;
   logic [31:0] IR = '0;
   logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout;
   logic        Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, run;
   logic [4:0]  alu_op;

   always #5 clk = ~clk;

   control_sequencer dut (
      .clk(clk), .clear(clear), .IR(IR), .mem_ready(mem_ready),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
      .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Cout(Cout),
      .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
      .BAout(BAout), .alu_op(alu_op), .run(run)
   );

   localparam logic [19:0] M_PCOUT  = 20'h80000;
   localparam logic [19:0] M_PCIN   = 20'h40000;
   localparam logic [19:0] M_INCPC  = 20'h20000;
   localparam logic [19:0] M_MARIN  = 20'h10000;
   localparam logic [19:0] M_MDRIN  = 20'h08000;
   localparam logic [19:0] M_MDROUT = 20'h04000;
   localparam logic [19:0] M_IRIN   = 20'h02000;
   localparam logic [19:0] M_YIN    = 20'h01000;
   localparam logic [19:0] M_ZIN    = 20'h00800;
   localparam logic [19:0] M_ZLOW   = 20'h00400;
   localparam logic [19:0] M_COUT   = 20'h00200;
   localparam logic [19:0] M_READ   = 20'h00100;
   localparam logic [19:0] M_WRITE  = 20'h00080;
   localparam logic [19:0] M_GRA    = 20'h00040;
   localparam logic [19:0] M_GRB    = 20'h00020;
   localparam logic [19:0] M_GRC    = 20'h00010;
   localparam logic [19:0] M_RIN    = 20'h00008;
   localparam logic [19:0] M_ROUT   = 20'h00004;
   localparam logic [19:0] M_BAOUT  = 20'h00002;
   localparam logic [19:0] M_RUN    = 20'h00001;
   localparam logic [19:0] T0_S     = M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN;
   localparam logic [19:0] T1_S     = M_ZLOW | M_PCIN | M_READ | M_MDRIN | M_RUN;

   typedef struct {
      logic [19:0] s;
      logic [4:0]  alu;
      bit          wt;
   } step_t;

   step_t       exp_q[$];
   int          n_tests = 0;
   int          n_fail = 0;
   logic [19:0] obs;

   assign obs = {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout,
                 Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, run};

   function automatic void push(input logic [19:0] s, input logic [4:0] alu, input bit wt);
      step_t e;
      e.s   = s | M_RUN;
      e.alu = alu;
      e.wt  = wt;
      exp_q.push_back(e);
   endfunction

   // Expected per-state strobe list for one instruction, straight from the class tables.
   function automatic void build(input logic [31:0] ir);
      int op;
      op = int'(ir[31:27]);
      exp_q.delete();
      push(T0_S, 5'd0, 1'b0);
      push(T1_S, 5'd0, 1'b1);
      push(M_MDROUT | M_IRIN, 5'd0, 1'b0);
      if (op >= 3 && op <= 11) begin
         push(M_GRB | M_ROUT | M_YIN, 5'd0, 1'b0);
         push(M_GRC | M_ROUT | M_ZIN, 5'(op), 1'b0);
         push(M_ZLOW | M_GRA | M_RIN, 5'd0, 1'b0);
      end else if (op >= 12 && op <= 14) begin
         push(M_GRB | M_ROUT | M_YIN, 5'd0, 1'b0);
         push(M_COUT | M_ZIN, 5'(op), 1'b0);
         push(M_ZLOW | M_GRA | M_RIN, 5'd0, 1'b0);
      end else if (op <= 2) begin
         push(M_GRB | M_BAOUT | M_YIN, 5'd0, 1'b0);
         push(M_COUT | M_ZIN, 5'd3, 1'b0);
         if (op == 1) begin
            push(M_ZLOW | M_GRA | M_RIN, 5'd0, 1'b0);
         end else begin
            push(M_ZLOW | M_MARIN, 5'd0, 1'b0);
            if (op == 0) begin
               push(M_READ | M_MDRIN, 5'd0, 1'b1);
               push(M_MDROUT | M_GRA | M_RIN, 5'd0, 1'b0);
            end else begin
               push(M_GRA | M_ROUT | M_MDRIN, 5'd0, 1'b0);
               push(M_WRITE, 5'd0, 1'b1);
            end
         end
      end else begin
         push(20'h0, 5'd0, 1'b0);
      end
   endfunction

   // Drives one instruction from T0 and compares every cycle; ends in the following T0 (or HALT).
   task automatic run_instr(input logic [31:0] ir, input string tag);
      int d;
      build(ir);
      IR = ir;
      foreach (exp_q[k]) begin
         d = 0;
`ifdef MEM_HANDSHAKE_EN
         if (exp_q[k].wt) d = int'($urandom_range(0, 3));
`endif
         for (int j = 0; j <= d; j++) begin
`ifdef MEM_HANDSHAKE_EN
            mem_ready = (j == d) || !exp_q[k].wt;
`else
            mem_ready = 1'($urandom);
`endif
            #1;
            n_tests++;
            if (obs !== exp_q[k].s || alu_op !== exp_q[k].alu) begin
               n_fail++;
               $display("FAIL %s step %0d: got strobes=%h alu=%h, want strobes=%h alu=%h",
                        tag, k, obs, alu_op, exp_q[k].s, exp_q[k].alu);
            end
            @(negedge clk);
         end
      end
      if (ir[31:27] != 5'b11011) begin
         #1;
         n_tests++;
         if (obs !== T0_S || alu_op !== 5'd0) begin
            n_fail++;
            $display("FAIL %s ret_t0: got strobes=%h alu=%h, want strobes=%h alu=0",
                     tag, obs, alu_op, T0_S);
         end
      end
   endtask

   task automatic do_reset();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic test_reset();
      clear = 1'b1;
      @(negedge clk);
      @(negedge clk);
      clear = 1'b0;
      #1;
      n_tests++;
      if (obs !== T0_S || alu_op !== 5'd0) begin
         n_fail++;
         $display("FAIL reset: got strobes=%h alu=%h, want strobes=%h alu=0", obs, alu_op, T0_S);
      end
      @(negedge clk);
      do_reset();
   endtask

   task automatic test_add();
      run_instr(32'h1A918000, "add");
   endtask

   task automatic test_ld();
      run_instr(32'h00900055, "ld");
      run_instr({5'b00001, 27'($urandom)}, "ldi");
   endtask

   task automatic test_st();
      run_instr({5'b00010, 27'($urandom)}, "st");
   endtask

   task automatic test_itype();
      for (int i = 12; i <= 14; i++) run_instr({5'(i), 27'($urandom)}, "itype");
   endtask

   task automatic test_unsupported();
      run_instr({5'b10000, 27'($urandom)}, "mul");
      run_instr({5'b11010, 27'($urandom)}, "nop");
   endtask

   task automatic test_halt();
      run_instr(32'hD8000000, "halt");
      for (int i = 0; i < 22; i++) begin
         mem_ready = 1'($urandom);
         #1;
         n_tests++;
         if (obs !== 20'h0 || alu_op !== 5'd0) begin
            n_fail++;
            $display("FAIL halt_hold cycle %0d: got strobes=%h alu=%h, want strobes=0 alu=0",
                     i, obs, alu_op);
         end
         @(negedge clk);
      end
      do_reset();
      #1;
      n_tests++;
      if (obs !== T0_S) begin
         n_fail++;
         $display("FAIL halt_exit: got strobes=%h, want strobes=%h", obs, T0_S);
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (obs !== T1_S) begin
         n_fail++;
         $display("FAIL halt_exit_t1: got strobes=%h, want strobes=%h", obs, T1_S);
      end
      do_reset();
   endtask

   task automatic test_clear_mid();
      do_reset();
      IR        = 32'h1A918000;
      mem_ready = 1'b1;
      repeat (4) @(negedge clk);
      clear = 1'b1;
      #1;
      n_tests++;
      if (obs !== (M_GRC | M_ROUT | M_ZIN | M_RUN) || alu_op !== 5'd3) begin
         n_fail++;
         $display("FAIL clear_leaving: got strobes=%h alu=%h, want strobes=%h alu=3",
                  obs, alu_op, M_GRC | M_ROUT | M_ZIN | M_RUN);
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (obs !== T0_S) begin
         n_fail++;
         $display("FAIL clear_hold: got strobes=%h, want strobes=%h", obs, T0_S);
      end
      @(negedge clk);
      clear = 1'b0;
      #1;
      n_tests++;
      if (PCout !== 1'b1 || IncPC !== 1'b1 || run !== 1'b1 || Rin !== 1'b0 || obs !== T0_S) begin
         n_fail++;
         $display("FAIL after_clear: got strobes=%h, want strobes=%h", obs, T0_S);
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (obs !== T1_S) begin
         n_fail++;
         $display("FAIL after_clear_t1: got strobes=%h, want strobes=%h", obs, T1_S);
      end
      do_reset();
   endtask

   task automatic test_back_to_back();
      logic [4:0] op;
      for (int i = 0; i < 40; i++) begin
         op = 5'($urandom_range(0, 31));
         if (op == 5'b11011) op = 5'b00011;
         run_instr({op, 27'($urandom)}, "random");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_add();
      test_ld();
      test_st();
      test_itype();
      test_unsupported();
      test_halt();
      test_clear_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
